// File: rtl/e4m3_pkg.sv
// e4m3_pkg: shared E4M3 types, constants and accumulator state encoding
package e4m3_pkg;
  typedef logic [7:0] e4m3_t;
  localparam e4m3_t E4M3_ZERO = 8'h00;
  localparam e4m3_t E4M3_NAN = 8'h7F;
  localparam int E4M3_BIAS = 7;
  localparam int E4M3_EXP_W = 4;
  localparam int E4M3_MAN_W = 3;
  typedef enum logic [1:0] {EMPTY, ACCUM, DONE} acc_state_t;
endpackage

// File: rtl/float_adder_e4m3.sv
// float_adder_e4m3: combinational E4M3 adder, round-to-nearest-even, saturating
// Ports: a, b - E4M3 operands; y - E4M3 sum.
// Operands are mapped to exact fixed point (LSB = 2^-9, the smallest subnormal),
// added exactly, then renormalised and rounded once. Overflow saturates to
// +/-448 (x7E); either NaN operand (S.1111.111) yields 8'h7F.
module float_adder_e4m3
  import e4m3_pkg::*;
(
  input  e4m3_t a,
  input  e4m3_t b,
  output e4m3_t y
);
  function automatic logic signed [19:0] to_fix(input e4m3_t x);
    logic [18:0] m;
    m = 19'({|x[6:3], x[2:0]}) << (x[6:3] == 4'd0 ? 4'd0 : x[6:3] - 4'd1);
    return x[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction
  logic signed [19:0] sum;
  logic [18:0] mag, low, half;
  logic [4:0] sh, exp_r;
  logic [2:0] keep, frac;
  logic rnd, ovf, sat, nan, sgn;
  int p;
  always_comb begin
    sum = to_fix(a) + to_fix(b);
    sgn = sum[19];
    mag = 19'(sgn ? -sum : sum);
    p = 0;
    for (int i = 0; i < 19; i++) if (mag[i]) p = i;
    sh = (p > 3) ? 5'(p - 3) : 5'd0;
    keep = 3'(mag >> sh);
    low = mag & ((19'd1 << sh) - 19'd1);
    half = (19'd1 << sh) >> 1;
    // round half to even on the bits shifted out below the 3-bit mantissa
    rnd = (sh != 5'd0) && (low > half || (low == half && keep[0]));
    {ovf, frac} = 4'(keep) + 4'(rnd);
    exp_r = 5'(p - 2) + 5'(ovf);
    sat = exp_r > 5'd15 || (exp_r == 5'd15 && frac == 3'd7);
    nan = a[6:0] == E4M3_NAN[6:0] || b[6:0] == E4M3_NAN[6:0];
    y = nan ? E4M3_NAN :
        p < 3 ? {sgn, 4'd0, mag[2:0]} :
        sat ? {sgn, 7'h7E} : {sgn, exp_r[3:0], frac};
  end
endmodule

// File: rtl/e4m3_stream_accumulator.sv
// e4m3_stream_accumulator: folds in_last-delimited E4M3 packets into one sum
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/in_data/in_last input
// stream; out_valid/out_ready/out_data/out_count/out_trunc result handshake.
// Optional macro E4M3_ACC_NAN_EN: sticky NaN flag forces out_data to 8'h7F.
module e4m3_stream_accumulator
  import e4m3_pkg::*;
#(
  parameter int MAX_LEN = 16,
  localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);
  acc_state_t state_q, state_d;
  e4m3_t acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic trunc_q, trunc_d, in_ready_q, out_valid_q, accept, full;
  float_adder_e4m3 u_add (.a(acc_q), .b(in_data), .y(sum));
  assign accept = in_valid && in_ready_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign full = cnt_inc == CNT_W'(MAX_LEN);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    trunc_d = trunc_q;
    case (state_q)
      EMPTY: if (accept) begin
        acc_d = in_data;
        cnt_d = CNT_W'(1);
        state_d = in_last ? DONE : ACCUM;
      end
      ACCUM: if (accept) begin
        acc_d = sum;
        cnt_d = cnt_inc;
        state_d = (in_last || full) ? DONE : ACCUM;
        trunc_d = full && !in_last;
      end
      DONE: if (out_ready) begin
        state_d = EMPTY;
        acc_d = E4M3_ZERO;
        cnt_d = '0;
        trunc_d = 1'b0;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      acc_q <= E4M3_ZERO;
      cnt_q <= '0;
      trunc_q <= 1'b0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      trunc_q <= trunc_d;
      in_ready_q <= state_d != DONE;
      out_valid_q <= state_d == DONE;
    end
  end
`ifdef E4M3_ACC_NAN_EN
  logic nan_q, nan_d;
  always_comb nan_d = (state_q == DONE && out_ready) ? 1'b0 :
                      nan_q | (accept && in_data[6:0] == E4M3_NAN[6:0]);
  always_ff @(posedge clk) nan_q <= rst_n ? nan_d : 1'b0;
  assign out_data = (state_q == DONE && nan_q) ? E4M3_NAN : acc_q;
`else
  assign out_data = acc_q;
`endif
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;
  assign out_trunc = trunc_q;
endmodule

// File: tb/tb_e4m3_stream_accumulator.sv
// tb_e4m3_stream_accumulator: directed self-checking bench, MAX_LEN=4
module tb_e4m3_stream_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = 8'h00;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic out_trunc;
  int vec = 0;
  int err = 0;

  e4m3_stream_accumulator #(.MAX_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vec++;
      err++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    vec++;
    if (out_data !== 8'h00 || out_count !== 3'd0 || out_trunc !== 1'b0) begin
      err++;
      $display("FAIL reset_out: data=%h count=%0d trunc=%b, want 00 0 0", out_data, out_count, out_trunc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b1) begin
      err++;
      $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_add(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [7:0] want);
    send(a, 1'b0);
    send(b, 1'b1);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || out_data !== want || out_count !== 3'd2 || out_trunc !== 1'b0) begin
      err++;
      $display("FAIL %s: valid=%b data=%h count=%0d trunc=%b, want 1 %h 2 0", nm, out_valid, out_data, out_count, out_trunc, want);
    end
    take();
  endtask

  task automatic test_single(input string nm, input logic [7:0] d);
    send(d, 1'b1);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || out_data !== d || out_count !== 3'd1 || out_trunc !== 1'b0) begin
      err++;
      $display("FAIL %s: valid=%b data=%h count=%0d trunc=%b, want 1 %h 1 0", nm, out_valid, out_data, out_count, out_trunc, d);
    end
    take();
  endtask

  task automatic test_backpressure();
    send(8'h40, 1'b0);
    send(8'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b1 || out_data !== 8'h48 || in_ready !== 1'b0) begin
        err++;
        $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b, want 1 48 0", i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    in_last = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if (out_valid !== 1'b0 || out_count !== 3'd0) begin
      err++;
      $display("FAIL bp_release: valid=%b count=%0d, want 0 0", out_valid, out_count);
    end
    test_single("bp_next", 8'h40);
  endtask

  task automatic test_trunc();
    for (int i = 0; i < 4; i++) begin
      send(8'h00, 1'b0);
      if (i == 2) begin
        vec++;
        if (out_valid !== 1'b0) begin
          err++;
          $display("FAIL trunc_early: valid=%b after 3 elements, want 0", out_valid);
        end
      end
    end
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || out_count !== 3'd4 || out_trunc !== 1'b1 || in_ready !== 1'b0) begin
      err++;
      $display("FAIL trunc_close: valid=%b data=%h count=%0d trunc=%b in_ready=%b, want 1 00 4 1 0", out_valid, out_data, out_count, out_trunc, in_ready);
    end
    take();
    test_single("trunc_fifth", 8'h00);
  endtask

  task automatic test_reset_mid();
    send(8'h40, 1'b0);
    send(8'h40, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00 || out_count !== 3'd0 || out_trunc !== 1'b0) begin
      err++;
      $display("FAIL rstmid_out: valid=%b ready=%b data=%h count=%0d trunc=%b, want 0 0 00 0 0", out_valid, in_ready, out_data, out_count, out_trunc);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (out_valid !== 1'b0) begin
      err++;
      $display("FAIL rstmid_noemit: valid=%b, want 0", out_valid);
    end
    test_single("rstmid_next", 8'h40);
  endtask

`ifdef E4M3_ACC_NAN_EN
  task automatic test_nan();
    send(8'h40, 1'b0);
    send(8'h7F, 1'b0);
    send(8'h40, 1'b1);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h7F || out_count !== 3'd3) begin
      err++;
      $display("FAIL nan_sticky: valid=%b data=%h count=%0d, want 1 7f 3", out_valid, out_data, out_count);
    end
    take();
    test_single("nan_cleared", 8'h40);
  endtask
`endif

  initial begin
    test_reset();
    test_add("add_2p2", 8'h40, 8'h40, 8'h48);
    test_add("add_small", 8'h28, 8'h10, 8'h29);
    test_add("add_absorb", 8'h50, 8'h10, 8'h50);
    test_add("add_cancel", 8'h40, 8'hC0, 8'h00);
    test_add("add_sat", 8'h7E, 8'h7E, 8'h7E);
    test_single("single", 8'h3C);
    test_backpressure();
    test_trunc();
    test_reset_mid();
`ifdef E4M3_ACC_NAN_EN
    test_nan();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t, want finish earlier", $time);
    $fatal(1);
  end
endmodule
